// File: rtl/mem_responder.sv
// Memory-side responder for the Mini SRC MDR/MAR interface.
// Serialised single-port RAM access with programmable wait states.
module mem_responder #(
    parameter int ADDR_WIDTH  = 9,
    parameter int WAIT_STATES = 2
) (
    input  logic        Clock,
    input  logic        Clear,
    input  logic [31:0] MARout,
    input  logic [31:0] MDRdata,
    input  logic        Read,
    input  logic        Write,
    output logic [31:0] Mdatain,
    output logic        MemDone,
    output logic        MemBusy
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [31:0]             wdata_q, wdata_d;
    logic                    wr_q, wr_d;
    logic                    done_q, done_d;
    logic [31:0]             rdata_q;
    logic                    mem_we;
    logic                    mem_re;
    logic [31:0]             ram [2**ADDR_WIDTH];

    // Upper MAR bits are deliberately ignored (address aliasing).
    logic unused_mar;
    assign unused_mar = ^MARout[31:ADDR_WIDTH];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        done_d  = 1'b0;
        mem_we  = 1'b0;
        mem_re  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (Read || Write) begin
                    addr_d  = MARout[ADDR_WIDTH-1:0];
                    wdata_d = MDRdata;
                    wr_d    = Write;
                    cnt_d   = 4'(WAIT_STATES);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    mem_we  = wr_q;
                    mem_re  = !wr_q;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Clear) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            wr_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            done_q  <= done_d;
        end
    end

    // Clear discards a pending write before it reaches the array.
    always_ff @(posedge Clock) begin
        if (mem_we && !Clear) begin
            ram[addr_q] <= wdata_q;
        end
    end

    always_ff @(posedge Clock) begin
        if (Clear) begin
            rdata_q <= 32'h0;
        end else if (mem_re) begin
            rdata_q <= ram[addr_q];
        end
    end

    assign Mdatain = rdata_q;
    assign MemDone = done_q;
    assign MemBusy = (state_q != IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Directed and randomised checks of mem_responder against a word-array model.
// Two instances: WAIT_STATES=2 (sel 0) and WAIT_STATES=0 (sel 1).
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        clr_a, rd_a, wr_a, clr_b, rd_b, wr_b;
    logic [31:0] mar_a, d_a, mar_b, d_b;
    logic [31:0] md_a, md_b;
    logic        done_a, busy_a, done_b, busy_b;

    int          errors = 0;
    int          checks = 0;

    logic [31:0] mm [2][512];
    logic [31:0] md [2];
    int          wsv [2] = '{2, 0};

    always #5 clk = ~clk;

    mem_responder #(.ADDR_WIDTH(9), .WAIT_STATES(2)) dut_a (
        .Clock(clk), .Clear(clr_a), .MARout(mar_a), .MDRdata(d_a),
        .Read(rd_a), .Write(wr_a), .Mdatain(md_a),
        .MemDone(done_a), .MemBusy(busy_a)
    );

    mem_responder #(.ADDR_WIDTH(9), .WAIT_STATES(0)) dut_b (
        .Clock(clk), .Clear(clr_b), .MARout(mar_b), .MDRdata(d_b),
        .Read(rd_b), .Write(wr_b), .Mdatain(md_b),
        .MemDone(done_b), .MemBusy(busy_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] f_md(input int sel);
        return sel ? md_b : md_a;
    endfunction

    function automatic logic f_done(input int sel);
        return sel ? done_b : done_a;
    endfunction

    function automatic logic f_busy(input int sel);
        return sel ? busy_b : busy_a;
    endfunction

    task automatic drive(input int sel, input logic w, input logic r,
                         input logic [31:0] mar, input logic [31:0] d);
        if (sel == 0) begin
            wr_a = w; rd_a = r; mar_a = mar; d_a = d;
        end else begin
            wr_b = w; rd_b = r; mar_b = mar; d_b = d;
        end
    endtask

    // One complete access; strobes drop right after acceptance and the
    // address/data inputs are scrambled to prove they were latched.
    task automatic acc(input int sel, input logic w, input logic r,
                       input logic [31:0] mar, input logic [31:0] d,
                       input string tag);
        int n;
        int a;
        a = int'(mar[8:0]);
        @(negedge clk);
        drive(sel, w, r, mar, d);
        @(posedge clk);
        #1;
        drive(sel, 1'b0, 1'b0, $urandom, $urandom);
        chk({tag, "_busy"}, 32'(f_busy(sel)), 32'd1);
        n = 0;
        while (n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (f_done(sel)) break;
        end
        chk({tag, "_lat"}, n, wsv[sel] + 1);
        if (w) mm[sel][a] = d;
        else md[sel] = mm[sel][a];
        chk({tag, "_data"}, f_md(sel), md[sel]);
        @(posedge clk);
        #1;
        chk({tag, "_dpulse"}, 32'(f_done(sel)), 32'd0);
        chk({tag, "_idle"}, 32'(f_busy(sel)), 32'd0);
    endtask

    initial begin
        int p;
        int ws;
        logic exp_done;
        logic [31:0] exp_md;
        logic [31:0] prev_md;

        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        clr_a = 1'b1;
        clr_b = 1'b1;
        md[0] = 32'h0;
        md[1] = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_md_a", md_a, 32'h0);
        chk("rst_done_a", 32'(done_a), 32'd0);
        chk("rst_busy_a", 32'(busy_a), 32'd0);
        chk("rst_md_b", md_b, 32'h0);
        chk("rst_busy_b", 32'(busy_b), 32'd0);
        @(negedge clk);
        clr_a = 1'b0;
        clr_b = 1'b0;

        acc(0, 1'b1, 1'b0, 32'h7, 32'h4A920000, "t1_wr");
        acc(0, 1'b0, 1'b1, 32'h7, 32'h0, "t2_rd");

        // Write then two held reads, back to back on a level strobe.
        ws = wsv[0];
        p = ws + 3;
        prev_md = md[0];
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 32'h5, 32'h27);
        @(posedge clk);
        @(negedge clk);
        drive(0, 1'b0, 1'b1, 32'h5, 32'h0);
        for (int e = 1; e <= 3 * p + 1; e++) begin
            @(posedge clk);
            #1;
            exp_done = (e % p == ws + 1) && (e < 3 * p);
            exp_md = (e >= p + ws + 1) ? 32'h27 : prev_md;
            chk($sformatf("t3_done_e%0d", e), 32'(done_a), 32'(exp_done));
            chk($sformatf("t3_md_e%0d", e), md_a, exp_md);
            if (e == 2 * p) rd_a = 1'b0;
        end
        chk("t3_idle", 32'(busy_a), 32'd0);
        mm[0][5] = 32'h27;
        md[0] = 32'h27;

        acc(0, 1'b1, 1'b1, 32'h2, 32'h4, "t4_both");
        acc(0, 1'b0, 1'b1, 32'h2, 32'h0, "t4_rd");

        // Abort a pending write with Clear one edge after acceptance.
        acc(0, 1'b1, 1'b0, 32'h3, 32'h2, "t5_pre");
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 32'h3, 32'hDEADBEEF);
        @(posedge clk);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        clr_a = 1'b1;
        @(posedge clk);
        #1;
        chk("t5_busy", 32'(busy_a), 32'd0);
        chk("t5_done", 32'(done_a), 32'd0);
        chk("t5_md", md_a, 32'h0);
        md[0] = 32'h0;
        @(negedge clk);
        clr_a = 1'b0;
        for (int e = 0; e < 6; e++) begin
            @(posedge clk);
            #1;
            chk("t5_nodone", 32'(done_a), 32'd0);
        end
        acc(0, 1'b0, 1'b1, 32'h3, 32'h0, "t5_rd");

        for (int s = 0; s < 2; s++) begin
            acc(s, 1'b1, 1'b0, 32'h207, 32'h12345678, "t6_wr");
            acc(s, 1'b0, 1'b1, 32'h7, 32'h0, "t6_rd");
        end

        // Random traffic over 16 words reached through aliased MAR values.
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 16; i++)
                acc(s, 1'b1, 1'b0, {$urandom_range(0, 8388607), 9'(i)},
                    $urandom, "r_init");
            for (int i = 0; i < 40; i++) begin
                logic w, r;
                w = 1'($urandom_range(0, 1));
                r = w ? 1'($urandom_range(0, 1)) : 1'b1;
                acc(s, w, r,
                    {$urandom_range(0, 8388607), 5'd0, 4'($urandom_range(0, 15))},
                    $urandom, "r_op");
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
